// File: rtl/bcd_count_ctrl_if.sv
// Control/status bundle between the button front end and the BCD counter.
// The master side issues requests; the slave side reports the count and state.
interface bcd_count_ctrl_if;
    logic       start;
    logic       pause;
    logic       dir;
    logic [7:0] limit;
    logic [7:0] q;
    logic [1:0] state;
    logic       busy;
    logic       done;

    modport master (
        output start, pause, dir, limit,
        input  q, state, busy, done
    );

    modport slave (
        input  start, pause, dir, limit,
        output q, state, busy, done
    );
endinterface

// File: rtl/bcd_count_ctrl.sv
// Two-digit BCD up/down counter with prescaled step strobe and an
// IDLE/RUN/PAUSE/DONE sequencer driven by one-cycle start/pause requests.
module bcd_count_ctrl #(
    parameter int TICK_DIV = 4
) (
    input logic             clk,
    input logic             rst,
    bcd_count_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [7:0]    q_q, q_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          dir_q, dir_d;
    logic [7:0]    lim_q, lim_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [7:0]    lim_s;
    logic [7:0]    stepped;
    logic [7:0]    end_v;
    logic          advance;

    function automatic logic [3:0] clamp9(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        pre_d   = pre_q;
        dir_d   = dir_q;
        lim_d   = lim_q;
        done_d  = 1'b0;

        lim_s   = {clamp9(bus.limit[7:4]), clamp9(bus.limit[3:0])};
        stepped = dir_q ? bcd_dec(q_q) : bcd_inc(q_q);
        end_v   = dir_q ? 8'h00 : lim_q;

        // The pause edge that resumes counting also advances the prescaler,
        // so a pause costs exactly the cycles spent in PAUSE.
        advance = ((state_q == RUN) && !bus.pause) ||
                  ((state_q == PAUSE) && bus.pause);

        if (bus.start) begin
            dir_d = bus.dir;
            lim_d = lim_s;
            pre_d = '0;
            if (lim_s == 8'h00) begin
                q_d     = 8'h00;
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                q_d     = bus.dir ? lim_s : 8'h00;
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                RUN:     if (bus.pause) state_d = PAUSE;
                PAUSE:   if (bus.pause) state_d = RUN;
                default: ;
            endcase

            if (advance) begin
                if (pre_q == PMAX) begin
                    pre_d = '0;
                    q_d   = stepped;
                    if (stepped == end_v) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
        end

        busy_d = (state_d == RUN) || (state_d == PAUSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= 8'h00;
            pre_q   <= '0;
            dir_q   <= 1'b0;
            lim_q   <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            pre_q   <= pre_d;
            dir_q   <= dir_d;
            lim_q   <= lim_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.state = state_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
